// File: rtl/mmio_sim_ctrl_if.sv
// Core data-port bundle shared by the CPU side and the TCM side of mmio_sim_ctrl.
// The master drives requests and the slave returns accept and responses.
interface mmio_sim_ctrl_if;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic        rd;
  logic [3:0]  wr;
  logic        cacheable;
  logic [10:0] req_tag;
  logic        invalidate;
  logic        writeback;
  logic        flush;
  logic [31:0] data_rd;
  logic        accept;
  logic        ack;
  logic        error;
  logic [10:0] resp_tag;

  modport master (
    output addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
    input  data_rd, accept, ack, error, resp_tag
  );

  modport slave (
    input  addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
    output data_rd, accept, ack, error, resp_tag
  );
endinterface

// File: rtl/mmio_sim_ctrl.sv
// Data-port shim between core and TCM serving a 256-byte simulation-control MMIO
// window locally; the timeout watchdog is built only when MMIO_SIM_WDOG_EN is defined.
module mmio_sim_ctrl #(
  parameter logic [31:0] MMIO_BASE       = 32'hF000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mmio_sim_ctrl_if.slave  cpu,
  mmio_sim_ctrl_if.master mem,
  output logic            done_o,
  output logic            timeout_o,
  output logic [31:0]     exit_code_o,
  output logic [31:0]     checksum_o,
  output logic [63:0]     cycle_count_o
);

  localparam logic [1:0] MAX_OUT      = 2'(MAX_OUTSTANDING);
  localparam logic [5:0] REG_DONE     = 6'h00;
  localparam logic [5:0] REG_CHECKSUM = 6'h01;
  localparam logic [5:0] REG_CYCLE_LO = 6'h02;
  localparam logic [5:0] REG_CYCLE_HI = 6'h03;
  localparam logic [5:0] REG_TIMEOUT  = 6'h04;
  localparam logic [5:0] REG_STATUS   = 6'h05;

  logic        cpu_is_rd;
  logic        cpu_is_wr;
  logic        cpu_is_maint;
  logic        cpu_req;
  logic        mmio_hit;
  logic        fwd_allowed;
  logic        fwd_gate;
  logic        fwd_fire;
  logic        local_ok;
  logic        local_fire;

  logic [1:0]  out_cnt_reg;
  logic [1:0]  out_cnt_next;
  logic        local_pend_reg;
  logic [10:0] local_tag_reg;
  logic [31:0] local_data_reg;
  logic        local_err_reg;

  logic        done_reg;
  logic        timeout_reg;
  logic [31:0] exit_code_reg;
  logic [31:0] checksum_reg;
  logic [31:0] checksum_next;
  logic [31:0] timeout_limit_reg;
  logic [63:0] cycle_reg;
  logic        timeout_hit;

  logic [5:0]  reg_idx;
  logic        reg_valid;
  logic [31:0] rd_mux;
  logic [31:0] wr_mask;
  logic        wr_local;
  logic        wr_done;
  logic        wr_checksum;

  // Request classification and window decode
  assign cpu_is_rd    = cpu.rd;
  assign cpu_is_wr    = (cpu.wr != 4'b0000);
  assign cpu_is_maint = cpu.flush | cpu.invalidate | cpu.writeback;
  assign cpu_req      = cpu_is_rd | cpu_is_wr | cpu_is_maint;
  assign mmio_hit     = (cpu_is_rd | cpu_is_wr) && (cpu.addr[31:8] == MMIO_BASE[31:8]);

  // A pending local response owns the response channel, so forwarding waits for it
  assign fwd_allowed = (out_cnt_reg != MAX_OUT) && !local_pend_reg;
  assign fwd_gate    = !mmio_hit && fwd_allowed;
  assign fwd_fire    = cpu_req && fwd_gate && mem.accept;

  // Local accesses only start with an empty downstream pipe to keep responses ordered
  assign local_ok   = (out_cnt_reg == 2'd0) && !local_pend_reg;
  assign local_fire = mmio_hit && local_ok;

  assign mem.addr       = cpu.addr;
  assign mem.data_wr    = cpu.data_wr;
  assign mem.cacheable  = cpu.cacheable;
  assign mem.req_tag    = cpu.req_tag;
  assign mem.rd         = cpu.rd & fwd_gate;
  assign mem.wr         = cpu.wr & {4{fwd_gate}};
  assign mem.invalidate = cpu.invalidate & fwd_gate;
  assign mem.writeback  = cpu.writeback & fwd_gate;
  assign mem.flush      = cpu.flush & fwd_gate;

  assign cpu.accept = mmio_hit ? local_ok : (mem.accept & fwd_allowed);

  // Response channel: the registered local response has priority over pass-through
  always_comb begin
    cpu.ack      = mem.ack;
    cpu.data_rd  = mem.data_rd;
    cpu.error    = mem.error;
    cpu.resp_tag = mem.resp_tag;
    if (local_pend_reg) begin
      cpu.ack      = 1'b1;
      cpu.data_rd  = local_data_reg;
      cpu.error    = local_err_reg;
      cpu.resp_tag = local_tag_reg;
    end
  end

  always_comb begin
    out_cnt_next = out_cnt_reg;
    if (fwd_fire && !mem.ack) begin
      out_cnt_next = out_cnt_reg + 2'd1;
    end else if (!fwd_fire && mem.ack && (out_cnt_reg != 2'd0)) begin
      out_cnt_next = out_cnt_reg - 2'd1;
    end
  end

  // Register file decode
  assign reg_idx = cpu.addr[7:2];

  always_comb begin
    rd_mux    = 32'd0;
    reg_valid = 1'b1;
    case (reg_idx)
      REG_DONE:     rd_mux = exit_code_reg;
      REG_CHECKSUM: rd_mux = checksum_reg;
      REG_CYCLE_LO: rd_mux = cycle_reg[31:0];
      REG_CYCLE_HI: rd_mux = cycle_reg[63:32];
      REG_TIMEOUT:  rd_mux = timeout_limit_reg;
      REG_STATUS:   rd_mux = {30'd0, timeout_reg, done_reg};
      default:      reg_valid = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_mask[gi*8 +: 8] = {8{cpu.wr[gi]}};
    end
  endgenerate

  assign wr_local      = local_fire && cpu_is_wr;
  assign wr_done       = wr_local && (reg_idx == REG_DONE);
  assign wr_checksum   = wr_local && (reg_idx == REG_CHECKSUM);
  assign checksum_next = (checksum_reg & ~wr_mask) | (cpu.data_wr & wr_mask);

`ifdef MMIO_SIM_WDOG_EN
  logic        wr_timeout;
  logic [31:0] timeout_limit_next;

  assign wr_timeout         = wr_local && (reg_idx == REG_TIMEOUT);
  assign timeout_limit_next = (timeout_limit_reg & ~wr_mask) | (cpu.data_wr & wr_mask);
  // Compared against the pre-increment low word, so expiry lands one count past the limit
  assign timeout_hit = (timeout_limit_reg != 32'd0) && !done_reg &&
                       (cycle_reg[31:0] >= timeout_limit_reg);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_limit_reg <= 32'd0;
    end else if (wr_timeout) begin
      timeout_limit_reg <= timeout_limit_next;
    end
  end
`else
  assign timeout_hit       = 1'b0;
  assign timeout_limit_reg = 32'd0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_reg    <= 2'd0;
      local_pend_reg <= 1'b0;
      local_tag_reg  <= 11'd0;
      local_data_reg <= 32'd0;
      local_err_reg  <= 1'b0;
    end else begin
      out_cnt_reg    <= out_cnt_next;
      local_pend_reg <= local_fire;
      if (local_fire) begin
        local_tag_reg  <= cpu.req_tag;
        local_data_reg <= rd_mux;
        local_err_reg  <= !reg_valid;
      end
    end
  end

  // Status state; the counter stops as soon as either terminal flag is up
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      exit_code_reg <= 32'd0;
      checksum_reg  <= 32'd0;
      cycle_reg     <= 64'd0;
    end else begin
      if (!done_reg && !timeout_reg) begin
        cycle_reg <= cycle_reg + 64'd1;
      end
      if (wr_done) begin
        done_reg      <= 1'b1;
        exit_code_reg <= cpu.data_wr;
      end
      if (wr_checksum) begin
        checksum_reg <= checksum_next;
      end
      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign done_o        = done_reg;
  assign timeout_o     = timeout_reg;
  assign exit_code_o   = exit_code_reg;
  assign checksum_o    = checksum_reg;
  assign cycle_count_o = cycle_reg;

endmodule

// File: tb/tb_mmio_sim_ctrl.sv
// Self-checking bench for mmio_sim_ctrl: scoreboard of expected responses plus a
// fixed-latency TCM model behind the shim.
module tb_mmio_sim_ctrl;

  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam int TCM_LAT = 3;
`ifdef MMIO_SIM_WDOG_EN
  localparam logic [31:0] EXP_TIMEOUT_RD = 32'd100;
  localparam logic [31:0] EXP_STATUS_TO  = 32'd2;
`else
  localparam logic [31:0] EXP_TIMEOUT_RD = 32'd0;
  localparam logic [31:0] EXP_STATUS_TO  = 32'd0;
`endif

  typedef struct {
    logic [10:0] tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    bit          chk_data;
  } exp_t;

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    int          due;
  } tcm_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done;
  logic        timeout;
  logic [31:0] exit_code;
  logic [31:0] checksum;
  logic [63:0] cycle_count;

  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc = 0;
  exp_t sb[$];
  tcm_t tcm_q[$];

  mmio_sim_ctrl_if cpu_bus ();
  mmio_sim_ctrl_if mem_bus ();

  mmio_sim_ctrl #(.MMIO_BASE(BASE), .MAX_OUTSTANDING(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu           (cpu_bus),
    .mem           (mem_bus),
    .done_o        (done),
    .timeout_o     (timeout),
    .exit_code_o   (exit_code),
    .checksum_o    (checksum),
    .cycle_count_o (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tcm_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic exp_t mk_exp(input logic [10:0] tag, input logic [31:0] lo,
                                  input logic [31:0] hi, input logic err, input bit chk);
    exp_t e;
    e.tag = tag; e.lo = lo; e.hi = hi; e.err = err; e.chk_data = chk;
    return e;
  endfunction

  // TCM model: always accepts, answers in order after TCM_LAT cycles
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      tcm_q.delete();
    end else if ((mem_bus.rd || (mem_bus.wr != 4'b0000)) && mem_bus.accept) begin
      tcm_t t;
      t.tag  = mem_bus.req_tag;
      t.data = mem_bus.rd ? tcm_data(mem_bus.addr) : 32'd0;
      t.due  = cyc + TCM_LAT;
      tcm_q.push_back(t);
    end
  end

  initial begin
    mem_bus.accept   = 1'b1;
    mem_bus.ack      = 1'b0;
    mem_bus.data_rd  = 32'd0;
    mem_bus.error    = 1'b0;
    mem_bus.resp_tag = 11'd0;
    forever begin
      @(posedge clk); #1;
      if (tcm_q.size() > 0 && tcm_q[0].due <= cyc) begin
        mem_bus.ack      = 1'b1;
        mem_bus.data_rd  = tcm_q[0].data;
        mem_bus.resp_tag = tcm_q[0].tag;
        void'(tcm_q.pop_front());
      end else begin
        mem_bus.ack      = 1'b0;
        mem_bus.data_rd  = 32'd0;
        mem_bus.resp_tag = 11'd0;
      end
    end
  end

  task automatic cpu_idle();
    cpu_bus.rd         = 1'b0;
    cpu_bus.wr         = 4'b0000;
    cpu_bus.flush      = 1'b0;
    cpu_bus.invalidate = 1'b0;
    cpu_bus.writeback  = 1'b0;
  endtask

  // Drives one request from posedge+1 and holds it until accepted; returns at posedge+1
  task automatic issue(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [10:0] tag, output bit accepted);
    cpu_bus.rd      = rd;
    cpu_bus.wr      = wr;
    cpu_bus.addr    = addr;
    cpu_bus.data_wr = wdata;
    cpu_bus.req_tag = tag;
    accepted = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_bus.accept) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_idle();
  endtask

  task automatic wait_ack(input int limit, output bit got, output int waited,
                          output logic [10:0] tag, output logic [31:0] data, output logic err);
    got = 1'b0; waited = 0; tag = 11'd0; data = 32'd0; err = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      waited++;
      if (cpu_bus.ack) begin
        got  = 1'b1;
        tag  = cpu_bus.resp_tag;
        data = cpu_bus.data_rd;
        err  = cpu_bus.error;
        $display("txn: ack tag=%0d data=%h err=%0b after %0d cycle(s)", tag, data, err, waited);
        break;
      end
    end
  endtask

  task automatic apply_reset();
    cpu_idle();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchecks++;
    if (done !== 1'b0 || timeout !== 1'b0 || exit_code !== 32'd0 || checksum !== 32'd0 ||
        cycle_count !== 64'd0) begin
      nerrors++;
      $display("FAIL reset_status: done=%b timeout=%b exit=%h cksum=%h cycles=%0d, required all 0",
               done, timeout, exit_code, checksum, cycle_count);
    end
    nchecks++;
    if (cpu_bus.ack !== 1'b0 || cpu_bus.error !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_resp: ack=%b error=%b, required 0 0", cpu_bus.ack, cpu_bus.error);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_cycle_read();
    bit acc, got;
    int waited;
    logic [10:0] rtag;
    logic [31:0] rdata;
    logic rerr;
    exp_t e;
    repeat (10) @(posedge clk);
    #1;
    issue(1'b1, 4'b0000, BASE + 32'h08, 32'd0, 11'd3, acc);
    sb.push_back(mk_exp(11'd3, 32'd9, 32'd11, 1'b0, 1'b1));
    nchecks++;
    if (!acc) begin nerrors++; $display("FAIL cycle_accept: accepted=%b, required 1", acc); end
    wait_ack(10, got, waited, rtag, rdata, rerr);
    e = sb.pop_front();
    nchecks++;
    if (!got || rtag !== e.tag || rerr !== e.err || $isunknown(rdata) || rdata < e.lo || rdata > e.hi) begin
      nerrors++;
      $display("FAIL cycle_resp: got=%b tag=%0d data=%0d err=%b, required tag=%0d data %0d..%0d err=%b",
               got, rtag, rdata, rerr, e.tag, e.lo, e.hi, e.err);
    end
    nchecks++;
    if (waited != 1) begin nerrors++; $display("FAIL cycle_latency: ack after %0d cycles, required 1", waited); end
  endtask

  task automatic test_checksum();
    logic [3:0]  wrs [2] = '{4'b0011, 4'b0000};
    logic [10:0] tags[2] = '{11'd5, 11'd6};
    bit acc, got;
    int waited;
    logic [10:0] rtag;
    logic [31:0] rdata;
    logic rerr;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      issue(wrs[i] == 4'b0000, wrs[i], BASE + 32'h04, 32'h1234_5678, tags[i], acc);
      sb.push_back(mk_exp(tags[i], 32'h0000_5678, 32'h0000_5678, 1'b0, wrs[i] == 4'b0000));
      wait_ack(10, got, waited, rtag, rdata, rerr);
      e = sb.pop_front();
      nchecks++;
      if (!acc || !got || waited != 1 || rtag !== e.tag || rerr !== e.err ||
          (e.chk_data && rdata !== e.lo)) begin
        nerrors++;
        $display("FAIL cksum_resp[%0d]: acc=%b got=%b lat=%0d tag=%0d data=%h err=%b, required lat 1 tag=%0d data=%h err=%b",
                 i, acc, got, waited, rtag, rdata, rerr, e.tag, e.lo, e.err);
      end
    end
    nchecks++;
    if (checksum !== 32'h0000_5678) begin
      nerrors++; $display("FAIL cksum_out: checksum_o=%h, required 00005678", checksum);
    end
  endtask

  task automatic test_outstanding();
    logic [31:0] addrs[2] = '{32'h0000_1000, 32'h0000_1004};
    bit acc, got;
    int waited, acks, acks_at_accept;
    logic [10:0] rtag;
    logic [31:0] rdata;
    logic rerr;
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 4'b0000, addrs[i], 32'd0, 11'(100 + i), acc);
      sb.push_back(mk_exp(11'(100 + i), tcm_data(addrs[i]), tcm_data(addrs[i]), 1'b0, 1'b1));
      nchecks++;
      if (!acc) begin nerrors++; $display("FAIL tcm_accept[%0d]: accepted=%b, required 1", i, acc); end
    end
    cpu_bus.rd      = 1'b1;
    cpu_bus.addr    = BASE + 32'h04;
    cpu_bus.req_tag = 11'd102;
    sb.push_back(mk_exp(11'd102, 32'h0000_5678, 32'h0000_5678, 1'b0, 1'b1));
    acks = 0; acks_at_accept = -1; acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_bus.ack) begin
        $display("txn: ack tag=%0d data=%h err=%0b", cpu_bus.resp_tag, cpu_bus.data_rd, cpu_bus.error);
        e = sb.pop_front();
        nchecks++;
        if (cpu_bus.resp_tag !== e.tag || cpu_bus.data_rd !== e.lo || cpu_bus.error !== e.err) begin
          nerrors++;
          $display("FAIL order_resp[%0d]: tag=%0d data=%h err=%b, required tag=%0d data=%h err=%b",
                   acks, cpu_bus.resp_tag, cpu_bus.data_rd, cpu_bus.error, e.tag, e.lo, e.err);
        end
        acks++;
      end
      if (cpu_bus.accept) begin
        acc = 1'b1;
        acks_at_accept = acks;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_idle();
    nchecks++;
    if (!acc || acks_at_accept != 2) begin
      nerrors++;
      $display("FAIL mmio_hold: accepted=%b after %0d TCM acks, required accept after 2", acc, acks_at_accept);
    end
    wait_ack(10, got, waited, rtag, rdata, rerr);
    e = sb.pop_front();
    nchecks++;
    if (!got || waited != 1 || rtag !== e.tag || rdata !== e.lo || rerr !== e.err) begin
      nerrors++;
      $display("FAIL mmio_after_tcm: got=%b lat=%0d tag=%0d data=%h err=%b, required lat 1 tag=%0d data=%h err=%b",
               got, waited, rtag, rdata, rerr, e.tag, e.lo, e.err);
    end
  endtask

  task automatic test_bad_offset();
    logic [31:0] offs [4] = '{32'h40, 32'h40, 32'h08, 32'h0C};
    logic [3:0]  wrs  [4] = '{4'h0, 4'hF, 4'hF, 4'h0};
    logic        errs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit          chks [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit acc, got;
    int waited;
    logic [10:0] rtag;
    logic [31:0] rdata;
    logic rerr;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      issue(wrs[i] == 4'h0, wrs[i], BASE + offs[i], 32'hFFFF_FFFF, 11'(7 + i), acc);
      sb.push_back(mk_exp(11'(7 + i), 32'd0, 32'd0, errs[i], chks[i]));
      wait_ack(10, got, waited, rtag, rdata, rerr);
      e = sb.pop_front();
      nchecks++;
      if (!acc || !got || waited != 1 || rtag !== e.tag || rerr !== e.err ||
          (e.chk_data && rdata !== e.lo)) begin
        nerrors++;
        $display("FAIL offset_resp[%0d]: acc=%b got=%b lat=%0d tag=%0d data=%h err=%b, required lat 1 tag=%0d data=%h err=%b",
                 i, acc, got, waited, rtag, rdata, rerr, e.tag, e.lo, e.err);
      end
    end
    nchecks++;
    if (cycle_count > 64'd1000) begin
      nerrors++; $display("FAIL ro_write: cycle_count_o=%0d, required below 1000", cycle_count);
    end
  endtask

  task automatic test_timeout();
    logic [3:0]  wrs [2] = '{4'hF, 4'h0};
    bit acc, got, found;
    int waited;
    logic [10:0] rtag;
    logic [31:0] rdata;
    logic rerr;
    logic [63:0] last_clear;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
`ifdef MMIO_SIM_WDOG_EN
        found = 1'b0; last_clear = 64'd0;
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (timeout) begin found = 1'b1; break; end
          last_clear = cycle_count;
        end
        nchecks++;
        if (!found || cycle_count !== 64'd101 || last_clear !== 64'd100) begin
          nerrors++;
          $display("FAIL wdog_expiry: fired=%b count=%0d prior=%0d, required fired at count 101 after 100",
                   found, cycle_count, last_clear);
        end
        repeat (5) @(negedge clk);
        nchecks++;
        if (cycle_count !== 64'd101) begin
          nerrors++; $display("FAIL wdog_freeze: cycle_count_o=%0d, required 101", cycle_count);
        end
`else
        repeat (150) @(negedge clk);
        nchecks++;
        if (timeout !== 1'b0 || cycle_count < 64'd150) begin
          nerrors++;
          $display("FAIL wdog_off: timeout_o=%b count=%0d, required 0 and counting", timeout, cycle_count);
        end
`endif
        @(posedge clk); #1;
        issue(1'b1, 4'h0, BASE + 32'h14, 32'd0, 11'd22, acc);
        sb.push_back(mk_exp(11'd22, EXP_STATUS_TO, EXP_STATUS_TO, 1'b0, 1'b1));
      end else begin
        issue(wrs[i] == 4'h0, wrs[i], BASE + 32'h10, 32'd100, 11'(20 + i), acc);
        sb.push_back(mk_exp(11'(20 + i), EXP_TIMEOUT_RD, EXP_TIMEOUT_RD, 1'b0, wrs[i] == 4'h0));
      end
      wait_ack(10, got, waited, rtag, rdata, rerr);
      e = sb.pop_front();
      nchecks++;
      if (!acc || !got || waited != 1 || rtag !== e.tag || rerr !== e.err ||
          (e.chk_data && rdata !== e.lo)) begin
        nerrors++;
        $display("FAIL timeout_resp[%0d]: acc=%b got=%b lat=%0d tag=%0d data=%h err=%b, required lat 1 tag=%0d data=%h err=%b",
                 i, acc, got, waited, rtag, rdata, rerr, e.tag, e.lo, e.err);
      end
    end
  endtask

  task automatic test_done();
    logic [31:0] offs [4] = '{32'h00, 32'h14, 32'h00, 32'h00};
    logic [3:0]  wrs  [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
    logic [31:0] wdat [4] = '{32'd7, 32'd0, 32'd9, 32'd0};
    logic [31:0] exps [4] = '{32'd0, 32'd1, 32'd0, 32'd9};
    bit acc, got;
    int waited;
    logic [10:0] rtag;
    logic [31:0] rdata;
    logic rerr;
    logic [63:0] snap;
    exp_t e;
    apply_reset();
    snap = 64'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      issue(wrs[i] == 4'h0, wrs[i], BASE + offs[i], wdat[i], 11'(30 + i), acc);
      sb.push_back(mk_exp(11'(30 + i), exps[i], exps[i], 1'b0, wrs[i] == 4'h0));
      wait_ack(10, got, waited, rtag, rdata, rerr);
      e = sb.pop_front();
      nchecks++;
      if (!acc || !got || waited != 1 || rtag !== e.tag || rerr !== e.err ||
          (e.chk_data && rdata !== e.lo)) begin
        nerrors++;
        $display("FAIL done_resp[%0d]: acc=%b got=%b lat=%0d tag=%0d data=%h err=%b, required lat 1 tag=%0d data=%h err=%b",
                 i, acc, got, waited, rtag, rdata, rerr, e.tag, e.lo, e.err);
      end
      if (i == 0) begin
        snap = cycle_count;
        nchecks++;
        if (done !== 1'b1 || exit_code !== 32'd7) begin
          nerrors++; $display("FAIL done_set: done_o=%b exit_code_o=%0d, required 1 and 7", done, exit_code);
        end
      end
    end
    nchecks++;
    if (done !== 1'b1 || exit_code !== 32'd9 || cycle_count !== snap || snap == 64'd0) begin
      nerrors++;
      $display("FAIL done_rewrite: done_o=%b exit=%0d count=%0d, required 1, 9, frozen at %0d",
               done, exit_code, cycle_count, snap);
    end
  endtask

  task automatic test_reset_pending();
    bit acc, got;
    int waited;
    logic [10:0] rtag;
    logic [31:0] rdata;
    logic rerr;
    exp_t e;
    @(posedge clk); #1;
    issue(1'b0, 4'hF, BASE + 32'h04, 32'h0000_00FF, 11'd40, acc);
    sb.push_back(mk_exp(11'd40, 32'd0, 32'd0, 1'b0, 1'b0));
    wait_ack(10, got, waited, rtag, rdata, rerr);
    e = sb.pop_front();
    nchecks++;
    if (!acc || !got || rtag !== e.tag || rerr !== e.err || checksum !== 32'h0000_00FF) begin
      nerrors++;
      $display("FAIL pre_reset_write: acc=%b got=%b tag=%0d err=%b cksum=%h, required tag=%0d err=0 cksum=000000ff",
               acc, got, rtag, rerr, checksum, e.tag);
    end
    @(posedge clk); #1;
    issue(1'b1, 4'h0, BASE + 32'h14, 32'd0, 11'd41, acc);
    rst = 1'b1;
    @(negedge clk);
    nchecks++;
    if (cpu_bus.ack !== 1'b0 || cpu_bus.error !== 1'b0 || cpu_bus.data_rd !== 32'd0 ||
        cpu_bus.resp_tag !== 11'd0 || done !== 1'b0 || timeout !== 1'b0 || exit_code !== 32'd0 ||
        checksum !== 32'd0 || cycle_count !== 64'd0) begin
      nerrors++;
      $display("FAIL reset_midflight: ack=%b err=%b data=%h tag=%0d done=%b to=%b exit=%h cksum=%h cycles=%0d, required all 0",
               cpu_bus.ack, cpu_bus.error, cpu_bus.data_rd, cpu_bus.resp_tag, done, timeout,
               exit_code, checksum, cycle_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ack(6, got, waited, rtag, rdata, rerr);
    nchecks++;
    if (got) begin
      nerrors++; $display("FAIL dropped_ack: ack seen tag=%0d, required none", rtag);
    end
  endtask

  initial begin
    cpu_bus.addr      = 32'd0;
    cpu_bus.data_wr   = 32'd0;
    cpu_bus.req_tag   = 11'd0;
    cpu_bus.cacheable = 1'b0;
    cpu_idle();
    test_reset();
    test_cycle_read();
    test_checksum();
    test_outstanding();
    test_bad_offset();
    test_timeout();
    test_done();
    test_reset_pending();
    nchecks++;
    if (sb.size() != 0) begin
      nerrors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end

endmodule
